// File: rtl/multi_region_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_region_lock_ctrl
// Purpose  : Per-region key-unlocked lock bits with sticky lock and global
//            wrong-key lockout, sitting between the command bus and gating.
// Revision : 1.0 - initial release
// ============================================================================
module multi_region_lock_ctrl #(
  parameter int                NUM_REGIONS = 4,
  parameter int                REGION_W    = 2,
  parameter int                KEY_W       = 32,
  parameter logic [KEY_W-1:0]  UNLOCK_KEY  = 32'hA5C3_0F1E,
  parameter int                MAX_FAILS   = 3,
  parameter int                FAIL_W      = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [REGION_W-1:0]    cmd_region,
  input  logic [KEY_W-1:0]       cmd_key,
  output logic                   resp_valid,
  output logic                   resp_ok,
  output logic [NUM_REGIONS-1:0] locked,
  output logic [NUM_REGIONS-1:0] sticky,
  output logic                   lockout,
  output logic [FAIL_W-1:0]      fail_count
);

  localparam logic [1:0]        OP_UNLOCK = 2'b00;
  localparam logic [1:0]        OP_RELOCK = 2'b01;
  localparam logic [1:0]        OP_STICKY = 2'b10;
  localparam logic [1:0]        OP_RSVD   = 2'b11;
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_RESP    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              op_q;
  logic [REGION_W-1:0]     region_q;
  logic [KEY_W-1:0]        key_q;
  logic                    key_match_q, region_valid_q, op_legal_q;

  logic [NUM_REGIONS-1:0]  sel;
  logic [NUM_REGIONS-1:0]  locked_nxt, sticky_nxt;
  logic [FAIL_W-1:0]       fail_nxt;
  logic                    resp_valid_nxt, resp_ok_nxt, lockout_nxt;

  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      op_q           <= '0;
      region_q       <= '0;
      key_q          <= '0;
      key_match_q    <= 1'b0;
      region_valid_q <= 1'b0;
      op_legal_q     <= 1'b0;
      locked         <= '1;
      sticky         <= '0;
      fail_count     <= '0;
      lockout        <= 1'b0;
      resp_valid     <= 1'b0;
      resp_ok        <= 1'b0;
    end else begin
      state      <= state_nxt;
      locked     <= locked_nxt;
      sticky     <= sticky_nxt;
      fail_count <= fail_nxt;
      lockout    <= lockout_nxt;
      resp_valid <= resp_valid_nxt;
      resp_ok    <= resp_ok_nxt;
      if (state == S_IDLE && cmd_valid) begin
        op_q     <= cmd_op;
        region_q <= cmd_region;
        key_q    <= cmd_key;
      end
      if (state == S_CHECK) begin
        key_match_q    <= (key_q == UNLOCK_KEY);
        region_valid_q <= (32'(region_q) < NUM_REGIONS);
        op_legal_q     <= (op_q != OP_RSVD);
      end
    end
  end

  // One-hot target mask; empty for out-of-range regions so no update can land.
  assign sel = region_valid_q ? (NUM_REGIONS'(1) << region_q) : '0;

  always_comb begin
    state_nxt      = state;
    locked_nxt     = locked;
    sticky_nxt     = sticky;
    fail_nxt       = fail_count;
    lockout_nxt    = lockout;
    resp_valid_nxt = 1'b0;
    resp_ok_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid_nxt = 1'b1;
        if (op_legal_q && region_valid_q) begin
          case (op_q)
            OP_UNLOCK: begin
              // Sticky regions reject before the key is evaluated.
              if ((sticky & sel) == '0) begin
                if (key_match_q) begin
                  locked_nxt  = locked & ~sel;
                  fail_nxt    = '0;
                  resp_ok_nxt = 1'b1;
                end else if (fail_count < FAIL_MAX) begin
                  fail_nxt = fail_count + FAIL_W'(1);
                end
              end
            end
            OP_RELOCK: begin
              locked_nxt  = locked | sel;
              resp_ok_nxt = 1'b1;
            end
            OP_STICKY: begin
              locked_nxt  = locked | sel;
              sticky_nxt  = sticky | sel;
              resp_ok_nxt = 1'b1;
            end
            default: ;
          endcase
        end
        if (fail_nxt == FAIL_MAX) begin
          state_nxt   = S_LOCKOUT;
          lockout_nxt = 1'b1;
          locked_nxt  = '1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        lockout_nxt = 1'b1;
        locked_nxt  = '1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_region_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_region_lock_ctrl
// Purpose  : Scoreboard bench for a 4-region and a 3-region instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_region_lock_ctrl;

  localparam logic [31:0] KEY = 32'hA5C3_0F1E;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  cv = '0;
  logic [1:0]  cmd_op = '0;
  logic [1:0]  cmd_region = '0;
  logic [31:0] cmd_key = '0;

  logic       rdy4, rv4, ok4, lo4;
  logic [3:0] lk4, st4;
  logic [1:0] fc4;
  logic       rdy3, rv3, ok3, lo3;
  logic [2:0] lk3, st3;
  logic [1:0] fc3;

  always #5 clk = ~clk;

  multi_region_lock_ctrl #(.NUM_REGIONS(4)) u4 (
    .clk(clk), .resetn(resetn), .cmd_valid(cv[0]), .cmd_ready(rdy4),
    .cmd_op(cmd_op), .cmd_region(cmd_region), .cmd_key(cmd_key),
    .resp_valid(rv4), .resp_ok(ok4), .locked(lk4), .sticky(st4),
    .lockout(lo4), .fail_count(fc4));

  multi_region_lock_ctrl #(.NUM_REGIONS(3)) u3 (
    .clk(clk), .resetn(resetn), .cmd_valid(cv[1]), .cmd_ready(rdy3),
    .cmd_op(cmd_op), .cmd_region(cmd_region), .cmd_key(cmd_key),
    .resp_valid(rv3), .resp_ok(ok3), .locked(lk3), .sticky(st3),
    .lockout(lo3), .fail_count(fc3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    bit         ok;
    logic [3:0] lk;
    logic [3:0] st;
    int         fc;
    bit         lo;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state: one slot per instance.
  logic [3:0] m_lk[2];
  logic [3:0] m_st[2];
  int         m_fc[2];
  bit         m_lo[2];
  int         nr[2] = '{4, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic dut_rdy(input int i);
    return (i == 0) ? rdy4 : rdy3;
  endfunction

  function automatic logic dut_lo(input int i);
    return (i == 0) ? lo4 : lo3;
  endfunction

  function automatic logic [3:0] all_mask(input int i);
    return (nr[i] == 4) ? 4'hF : 4'h7;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lk[i] = all_mask(i);
      m_st[i] = '0;
      m_fc[i] = 0;
      m_lo[i] = 1'b0;
    end
  endfunction

  // Apply one command to the reference state and return the expected response.
  function automatic exp_t model_step(input int i, input int op, input int r, input logic [31:0] key);
    exp_t e;
    bit ok = 1'b0;
    bit vr = (r < nr[i]);
    case (op)
      0: if (vr && !m_st[i][r]) begin
           if (key == KEY) begin
             m_lk[i][r] = 1'b0;
             m_fc[i] = 0;
             ok = 1'b1;
           end else if (m_fc[i] < 3) begin
             m_fc[i] = m_fc[i] + 1;
           end
         end
      1: if (vr) begin m_lk[i][r] = 1'b1; ok = 1'b1; end
      2: if (vr) begin m_lk[i][r] = 1'b1; m_st[i][r] = 1'b1; ok = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (m_fc[i] == 3) begin
      m_lo[i] = 1'b1;
      m_lk[i] = all_mask(i);
    end
    e.cyc = 0;
    e.ok  = ok;
    e.lk  = m_lk[i];
    e.st  = m_st[i];
    e.fc  = m_fc[i];
    e.lo  = m_lo[i];
    return e;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_locked4", lk4, 4'hF);
    chk("rst_locked3", lk3, 3'h7);
    chk("rst_sticky", {st4, 1'b0, st3}, 8'h0);
    chk("rst_fail", {fc4, fc3}, 4'h0);
    chk("rst_lockout", {lo4, lo3}, 2'b00);
    chk("rst_resp", {rv4, ok4, rv3, ok3}, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;
  endtask

  task automatic send(input int i, input int op, input int r, input logic [31:0] key, input bit abort = 1'b0);
    exp_t e;
    int   n;
    int   acc;
    if (m_lo[i]) begin
      repeat (3) @(negedge clk);
      cmd_op = 2'(op); cmd_region = 2'(r); cmd_key = key;
      cv[i] = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("lockout_ready", dut_rdy(i), 1'b0);
        chk("lockout_flag", dut_lo(i), 1'b1);
      end
      cv[i] = 1'b0;
      return;
    end
    @(negedge clk);
    n = 0;
    while (dut_rdy(i) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      fail_now("ready_timeout");
      return;
    end
    cmd_op = 2'(op); cmd_region = 2'(r); cmd_key = key;
    cv[i] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    cv[i] = 1'b0;
    // Garbage on the bus while busy must not matter.
    cmd_op = 2'($urandom); cmd_region = 2'($urandom); cmd_key = $urandom;
    e = model_step(i, op, r, key);
    e.cyc = acc + 2;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    if (abort) begin
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_reset_outputs();
      q0.delete();
      q1.delete();
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_locked", lk4, 4'hF);
    end
  endtask

  task automatic mon(input int i);
    exp_t       e;
    logic       rv, ok, lo;
    logic [3:0] lk, st;
    logic [1:0] fc;
    if (i == 0) begin
      rv = rv4; ok = ok4; lo = lo4; lk = lk4; st = st4; fc = fc4;
    end else begin
      rv = rv3; ok = ok3; lo = lo3; lk = {1'b0, lk3}; st = {1'b0, st3}; fc = fc3;
    end
    if (rv === 1'b1) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        fail_now($sformatf("unexpected_resp inst%0d", i));
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("resp_cycle%0d", i), cyc, e.cyc);
        chk($sformatf("resp_ok%0d", i), ok, e.ok);
        chk($sformatf("locked%0d", i), lk, e.lk);
        chk($sformatf("sticky%0d", i), st, e.st);
        chk($sformatf("fail_count%0d", i), fc, e.fc);
        chk($sformatf("lockout%0d", i), lo, e.lo);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    model_reset();
    do_reset();

    send(0, 0, 2, KEY);
    repeat (3) send(0, 0, 1, 32'hDEAD_BEEF);
    send(0, 0, 1, KEY);

    do_reset();
    send(0, 0, 0, 32'h1);
    send(0, 0, 0, 32'h2);
    send(0, 0, 0, KEY);
    send(0, 2, 3, 32'h0);
    send(0, 0, 3, KEY);
    send(0, 0, 0, KEY);
    send(0, 1, 0, 32'h5);
    send(0, 3, 0, KEY);

    send(1, 0, 3, KEY);
    send(1, 0, 3, 32'h0BAD);
    send(1, 2, 3, 32'h0);
    send(1, 1, 3, 32'h0);
    send(1, 0, 1, KEY);

    repeat (4) @(negedge clk);
    send(0, 0, 1, KEY, 1'b1);

    for (int k = 0; k < 300; k++) begin
      int i   = int'($urandom_range(1, 0));
      int op  = int'($urandom_range(9, 0));
      int r   = int'($urandom_range(3, 0));
      logic [31:0] key = ($urandom_range(3, 0) != 0) ? KEY : $urandom;
      op = (op < 5) ? 0 : (op < 7) ? 1 : (op < 9) ? 2 : 3;
      send(i, op, r, key);
      if (k % 40 == 39) do_reset();
    end

    repeat (6) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
